// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

   localparam logic [3:0] AN_ALL_OFF  = 4'b1111;
   localparam int         DIGIT_IDX_W = 2;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } seg_state_e;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  blank;
   } disp_set_t;

   // Active-low anode pattern lighting only digit idx.
   function automatic logic [3:0] an_onehot_n(input logic [DIGIT_IDX_W-1:0] idx);
      an_onehot_n = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the display scan; emits slot/frame start
// strobes and a blank_done strobe on the first cycle past the blanking gap.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   slot_start,
   output logic                   blank_done,
   output logic                   frame_start,
   output logic [DIGIT_IDX_W-1:0] digit_idx
);

   localparam int               CNT_W    = $clog2(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0]       cnt_r;
   logic [DIGIT_IDX_W-1:0] idx_r;

   // Slot counter wraps each slot and advances the digit index on wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         idx_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
         idx_r <= idx_r + DIGIT_IDX_W'(1);
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign slot_start  = (cnt_r == '0);
   assign blank_done  = (cnt_r == CNT_SHOW);
   assign frame_start = slot_start && (idx_r == '0);
   assign digit_idx   = idx_r;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with tear-free frame-boundary loads.
// Optional per-digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_FRAMES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] digits_in,
   input  logic [3:0]  blank_in,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [3:0]  blink_mask,
`endif
   output logic [3:0]  bcd_out,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx,
   output logic        frame_tick
);

   localparam disp_set_t SET_RESET = '{digits: 16'h0000, blank: 4'hF};

   if (DIGIT_CYCLES < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES || BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_scan_ctrl: illegal parameter combination");
   end

   logic                   slot_start_s, blank_done_s, frame_start_s;
   logic [DIGIT_IDX_W-1:0] timer_idx_s;
   disp_set_t              pend_r, active_r, show_set_s;
   logic                   pend_full_r, load_ready_r, accept_s, commit_s;
   seg_state_e             state_r, state_nxt_s;
   logic [3:0]             dark_mask_s, an_nxt_s, bcd_nxt_s, an_r, bcd_r;
   logic [1:0]             digit_idx_r;
   logic                   frame_tick_r, masked_s;

   seg_slot_timer #(
      .DIGIT_CYCLES(DIGIT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot_start (slot_start_s),
      .blank_done (blank_done_s),
      .frame_start(frame_start_s),
      .digit_idx  (timer_idx_s)
   );

   assign accept_s = load_valid && load_ready_r;
   assign commit_s = frame_start_s && pend_full_r;

   // Pending/active double buffer; swaps only at a frame boundary so a frame never mixes sets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r       <= SET_RESET;
         pend_full_r  <= 1'b0;
         active_r     <= SET_RESET;
         load_ready_r <= 1'b1;
      end else begin
         if (accept_s) begin
            pend_r      <= '{digits: digits_in, blank: blank_in};
            pend_full_r <= 1'b1;
         end else if (commit_s) begin
            pend_full_r <= 1'b0;
         end
         if (commit_s) begin
            active_r <= pend_r;
         end
         load_ready_r <= accept_s ? 1'b0 : !pend_full_r;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int                 BLINK_W    = $clog2(2 * BLINK_FRAMES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES);

   logic [BLINK_W-1:0] blink_cnt_r, blink_nxt_s, blink_cur_s;

   // Blink phase for the frame being emitted; the first frame after reset is frame 0.
   always_comb begin
      blink_nxt_s = '0;
      blink_cur_s = blink_cnt_r;
      dark_mask_s = 4'b0000;
      if (blink_cnt_r == BLINK_LAST) begin
         blink_nxt_s = '0;
      end else begin
         blink_nxt_s = blink_cnt_r + BLINK_W'(1);
      end
      if (frame_start_s) begin
         blink_cur_s = blink_nxt_s;
      end else begin
         blink_cur_s = blink_cnt_r;
      end
      if (blink_cur_s >= BLINK_HALF) begin
         dark_mask_s = blink_mask;
      end else begin
         dark_mask_s = 4'b0000;
      end
   end

   // Frame counter; starts at its last value so the first frame_start lands on 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_r <= BLINK_LAST;
      end else if (frame_start_s) begin
         blink_cnt_r <= blink_nxt_s;
      end
   end
`else
   assign dark_mask_s = 4'b0000;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BLANK;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: every slot opens in BLANK unless blanking is disabled.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BLANK: begin
            if (slot_start_s) begin
               state_nxt_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            end else if (blank_done_s) begin
               state_nxt_s = ST_SHOW;
            end else begin
               state_nxt_s = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (slot_start_s) begin
               state_nxt_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            end else begin
               state_nxt_s = ST_SHOW;
            end
         end
         default: state_nxt_s = ST_BLANK;
      endcase
   end

   // Output decode; on a commit cycle the incoming set is used so slot 0 shows it.
   always_comb begin
      show_set_s = active_r;
      masked_s   = 1'b1;
      an_nxt_s   = AN_ALL_OFF;
      bcd_nxt_s  = 4'h0;
      if (commit_s) begin
         show_set_s = pend_r;
      end else begin
         show_set_s = active_r;
      end
      masked_s  = show_set_s.blank[timer_idx_s] | dark_mask_s[timer_idx_s];
      bcd_nxt_s = show_set_s.digits[{timer_idx_s, 2'b00} +: 4];
      if (state_nxt_s == ST_SHOW && !masked_s) begin
         an_nxt_s = an_onehot_n(timer_idx_s);
      end else begin
         an_nxt_s = AN_ALL_OFF;
      end
   end

   // Output registers; bcd_out/digit_idx load at slot start and hold through the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r         <= AN_ALL_OFF;
         bcd_r        <= 4'h0;
         digit_idx_r  <= 2'd0;
         frame_tick_r <= 1'b0;
      end else begin
         an_r         <= an_nxt_s;
         frame_tick_r <= frame_start_s;
         if (slot_start_s) begin
            bcd_r       <= bcd_nxt_s;
            digit_idx_r <= timer_idx_s;
         end
      end
   end

   assign an         = an_r;
   assign bcd_out    = bcd_r;
   assign digit_idx  = digit_idx_r;
   assign frame_tick = frame_tick_r;
   assign load_ready = load_ready_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2).
module tb_seg_scan_ctrl;

   localparam int DC = 8;
   localparam int BC = 2;
   localparam int BF = 2;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  blank;
      logic [15:0] exp_seq;   // expected bcd per slot, slot 0 in the top nibble
      logic [3:0]  exp_lit;   // bit k: digit k expected to light
      int          nframes;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [3:0] bcd;
      logic [1:0] idx;
      logic       ft;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  blank_in = 4'h0;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]  blink_mask = 4'h0;
`endif
   logic        load_ready, frame_tick;
   logic [3:0]  bcd_out, an;
   logic [1:0]  digit_idx;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   vec_t vecs[4];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .digits_in (digits_in),
      .blank_in  (blank_in),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .bcd_out   (bcd_out),
      .an        (an),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Advance to the next frame_tick, counting ready-high and lit cycles on the way.
   task automatic wait_tick(output int ready_hi, output int an_lit);
      ready_hi = 0;
      an_lit   = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (frame_tick) return;
         if (load_ready) ready_hi++;
         if (an != 4'hF) an_lit++;
      end
      bound_fail("wait_tick");
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] b);
      bit found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (load_ready) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) bound_fail("do_load_ready");
      load_valid = 1'b1;
      digits_in  = d;
      blank_in   = b;
      @(negedge clk);
      load_valid = 1'b0;
      check("ready_drop_after_accept", load_ready, 1'b0);
   endtask

   // Called on the frame_tick cycle; checks one full frame and ends on the next frame's first cycle.
   task automatic check_frame(input logic [15:0] seq, input logic [3:0] lit, input logic [3:0] dark);
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < DC; c++) begin
            e.an  = (c < BC || !lit[s] || dark[s]) ? 4'hF : ~(4'b0001 << s);
            e.bcd = seq[15 - 4*s -: 4];
            e.idx = 2'(s);
            e.ft  = (s == 0 && c == 0);
            sb_q.push_back(e);
         end
      end
      for (int i = 0; i < 4 * DC; i++) begin
         e = sb_q.pop_front();
         check($sformatf("an s%0d c%0d", i / DC, i % DC), an, e.an);
         check($sformatf("bcd s%0d c%0d", i / DC, i % DC), bcd_out, e.bcd);
         check($sformatf("idx s%0d c%0d", i / DC, i % DC), digit_idx, e.idx);
         check($sformatf("tick s%0d c%0d", i / DC, i % DC), frame_tick, e.ft);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rh, al;
      logic [3:0] dark;

      vecs[0] = '{16'h1234, 4'b0000, 16'h4321, 4'b1111, 1};
      vecs[1] = '{16'h9870, 4'b0100, 16'h0789, 4'b1011, 3};
      vecs[2] = '{16'h5555, 4'b1111, 16'h5555, 4'b0000, 1};
      vecs[3] = '{16'h0609, 4'b1001, 16'h9060, 4'b0110, 1};

      // Reset state, then all dark until the first commit
      #2 rst_n = 1'b0;
      #3;
      check("rst_an", an, 4'hF);
      check("rst_ready", load_ready, 1'b1);
      check("rst_bcd", bcd_out, 4'h0);
      check("rst_idx", digit_idx, 2'd0);
      check("rst_tick", frame_tick, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_tick", frame_tick, 1'b1);
      check("first_an", an, 4'hF);
      wait_tick(rh, al);
      check("dark_before_commit", al, 0);

      // Table-driven loads issued mid-frame
      for (int v = 0; v < 4; v++) begin
         repeat (4) @(negedge clk);
         do_load(vecs[v].digits, vecs[v].blank);
         wait_tick(rh, al);
         check("ready_low_until_tick", rh, 0);
         check("ready_low_at_tick", load_ready, 1'b0);
         for (int f = 0; f < vecs[v].nframes; f++) begin
            check_frame(vecs[v].exp_seq, vecs[v].exp_lit, 4'h0);
         end
      end

      // Back-to-back loads: second one held until one cycle after frame_tick
      repeat (4) @(negedge clk);
      load_valid = 1'b1;
      digits_in  = 16'h1111;
      blank_in   = 4'h0;
      @(negedge clk);
      check("bb_first_accept", load_ready, 1'b0);
      digits_in = 16'h2222;
      wait_tick(rh, al);
      check("bb_held_no_ready", rh, 0);
      check("bb_ready_low_at_tick", load_ready, 1'b0);
      fork
         check_frame(16'h1111, 4'hF, 4'h0);
         begin
            @(negedge clk);
            check("bb_ready_after_tick", load_ready, 1'b1);
            @(negedge clk);
            load_valid = 1'b0;
            check("bb_second_accept", load_ready, 1'b0);
         end
      join
      check_frame(16'h2222, 4'hF, 4'h0);

      // Asynchronous reset mid-SHOW of slot 2 with a load pending
      repeat (19) @(negedge clk);
      load_valid = 1'b1;
      digits_in  = 16'hFFFF;
      blank_in   = 4'h0;
      @(negedge clk);
      load_valid = 1'b0;
      check("pre_rst_ready", load_ready, 1'b0);
      check("pre_rst_an", an, 4'b1011);
      check("pre_rst_idx", digit_idx, 2'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_an", an, 4'hF);
      check("async_rst_ready", load_ready, 1'b1);
      check("async_rst_bcd", bcd_out, 4'h0);
      check("async_rst_idx", digit_idx, 2'd0);
      check("async_rst_tick", frame_tick, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef SEG_SCAN_BLINK_EN
      blink_mask = 4'b0001;
`endif
      @(negedge clk);
      check("post_rst_tick", frame_tick, 1'b1);
      check("post_rst_ready", load_ready, 1'b1);
      do_load(16'h1234, 4'h0);
      wait_tick(rh, al);
      check("pending_cleared_by_reset", al, 0);

      // Frames 1..6 after reset; with blinking, digit 0 is dark in frames 2-3 and 6
      for (int f = 1; f <= 6; f++) begin
         dark = 4'h0;
`ifdef SEG_SCAN_BLINK_EN
         if (((f / BF) % 2) == 1) dark = 4'b0001;
`endif
         check_frame(16'h4321, 4'hF, dark);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
